// File: rtl/pe_ctrl_pkg.sv
// Shared types, default widths and config clamp for the PE bit-slice
// accumulate controller.
package pe_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int SLICE_BITS     = 2;
  localparam int SUM_W_DEF      = 10;
  localparam int ACC_W_DEF      = 24;
  localparam int MAX_SLICES_DEF = 4;

  function automatic logic [2:0] clamp_slices(
    input logic [2:0] c,
    input logic [2:0] max_s
  );
    if (c == 3'd0) return 3'd1;
    if (c > max_s) return max_s;
    return c;
  endfunction

endpackage

// File: rtl/pe_bitslice_acc_ctrl_step_counter.sv
// Nested a/w/chunk step counter; a-slice innermost, chunk outermost.
// Wraps to all-zero after the last step.
module pe_step_counter
  import pe_ctrl_pkg::*;
#(
  parameter int CHUNK_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic [2:0]            a_n,
  input  logic [2:0]            w_n,
  input  logic [CHUNK_W-1:0]    ch_n,
  output logic [SLICE_BITS-1:0] sel_a,
  output logic [SLICE_BITS-1:0] sel_w,
  output logic [CHUNK_W-1:0]    chunk_idx,
  output logic                  last_step
);

  logic [SLICE_BITS-1:0] a_q, a_d;
  logic [SLICE_BITS-1:0] w_q, w_d;
  logic [CHUNK_W-1:0]    c_q, c_d;
  logic                  a_last, w_last, c_last;

  always_comb begin
    a_last    = ({1'b0, a_q} == (a_n - 3'd1));
    w_last    = ({1'b0, w_q} == (w_n - 3'd1));
    c_last    = (c_q == (ch_n - CHUNK_W'(1)));
    last_step = a_last && w_last && c_last;
    a_d = a_q;
    w_d = w_q;
    c_d = c_q;
    if (clr) begin
      a_d = '0;
      w_d = '0;
      c_d = '0;
    end else if (en) begin
      if (a_last) begin
        a_d = '0;
        if (w_last) begin
          w_d = '0;
          c_d = c_last ? '0 : c_q + CHUNK_W'(1);
        end else begin
          w_d = w_q + SLICE_BITS'(1);
        end
      end else begin
        a_d = a_q + SLICE_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q <= '0;
      w_q <= '0;
      c_q <= '0;
    end else begin
      a_q <= a_d;
      w_q <= w_d;
      c_q <= c_d;
    end
  end

  assign sel_a     = a_q;
  assign sel_w     = w_q;
  assign chunk_idx = c_q;

endmodule

// File: rtl/pe_bitslice_acc_ctrl.sv
// Bit-slice dot-product sequencer: steps slices/chunks, shifts and sums
// pe_sum. Define PE_ACC_SAT_EN for a saturating accumulator + acc_sat.
module pe_bitslice_acc_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int SUM_W      = SUM_W_DEF,
  parameter int ACC_W      = ACC_W_DEF,
  parameter int MAX_SLICES = MAX_SLICES_DEF,
  parameter int CHUNK_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               start_ready,
  input  logic [2:0]         cfg_a_slices,
  input  logic [2:0]         cfg_w_slices,
  input  logic [CHUNK_W-1:0] cfg_chunks,
  input  logic [SUM_W-1:0]   pe_sum,
  output logic [1:0]         sel_a_slice,
  output logic [1:0]         sel_w_slice,
  output logic [CHUNK_W-1:0] chunk_idx,
  output logic               step_valid,
  output logic [ACC_W-1:0]   result,
  output logic               result_valid,
  input  logic               result_ready
`ifdef PE_ACC_SAT_EN
  ,
  output logic               acc_sat
`endif
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d, acc_next;
  logic [ACC_W-1:0]   result_q, result_d;
  logic               rv_q, rv_d;
  logic               sv_q, sv_d;
  logic               sr_q, sr_d;
  logic [2:0]         a_n_q, a_n_d;
  logic [2:0]         w_n_q, w_n_d;
  logic [CHUNK_W-1:0] ch_n_q, ch_n_d;
  logic               clr, en, last_step;
  logic [3:0]         shamt;
  logic               ovf;

  pe_step_counter #(
    .CHUNK_W (CHUNK_W)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .en        (en),
    .a_n       (a_n_q),
    .w_n       (w_n_q),
    .ch_n      (ch_n_q),
    .sel_a     (sel_a_slice),
    .sel_w     (sel_w_slice),
    .chunk_idx (chunk_idx),
    .last_step (last_step)
  );

  assign shamt = {1'b0, sel_a_slice} + {1'b0, sel_w_slice};

`ifdef PE_ACC_SAT_EN
  // Wide enough that neither the shifted term nor the sum can overflow.
  localparam int SH_MAX = 2 * SLICE_BITS * (MAX_SLICES - 1);
  localparam int EXT_W  =
    ((ACC_W > SUM_W + SH_MAX) ? ACC_W : SUM_W + SH_MAX) + 1;
  localparam logic signed [EXT_W-1:0] ACC_MAX =
    (EXT_W'(1) <<< (ACC_W - 1)) - EXT_W'(1);
  localparam logic signed [EXT_W-1:0] ACC_MIN =
    -(EXT_W'(1) <<< (ACC_W - 1));

  logic signed [EXT_W-1:0] term_x, sum_x;
  logic                    sat_q, sat_d;

  always_comb begin
    term_x = EXT_W'($signed(pe_sum)) <<< {shamt, 1'b0};
    sum_x  = EXT_W'($signed(acc_q)) + term_x;
    ovf    = 1'b0;
    if (sum_x > ACC_MAX) begin
      acc_next = ACC_MAX[ACC_W-1:0];
      ovf      = 1'b1;
    end else if (sum_x < ACC_MIN) begin
      acc_next = ACC_MIN[ACC_W-1:0];
      ovf      = 1'b1;
    end else begin
      acc_next = sum_x[ACC_W-1:0];
    end
  end

  assign acc_sat = sat_q;
`else
  logic [ACC_W-1:0] term_w;

  always_comb begin
    term_w = {{(ACC_W-SUM_W){pe_sum[SUM_W-1]}}, pe_sum} << {shamt, 1'b0};
    acc_next = acc_q + term_w;
    ovf      = 1'b0;
  end
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    result_d = result_q;
    a_n_d    = a_n_q;
    w_n_d    = w_n_q;
    ch_n_d   = ch_n_q;
    clr      = 1'b0;
    en       = 1'b0;
`ifdef PE_ACC_SAT_EN
    sat_d    = sat_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          acc_d   = '0;
          clr     = 1'b1;
          a_n_d   = clamp_slices(cfg_a_slices, 3'(MAX_SLICES));
          w_n_d   = clamp_slices(cfg_w_slices, 3'(MAX_SLICES));
          ch_n_d  = (cfg_chunks == '0) ? CHUNK_W'(1) : cfg_chunks;
`ifdef PE_ACC_SAT_EN
          sat_d   = 1'b0;
`endif
        end
      end
      S_RUN: begin
        en    = 1'b1;
        acc_d = acc_next;
`ifdef PE_ACC_SAT_EN
        sat_d = sat_q | ovf;
`endif
        if (last_step) begin
          state_d  = S_DONE;
          result_d = acc_next;
        end
      end
      S_DONE: begin
        if (result_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    sv_d = (state_d == S_RUN);
    rv_d = (state_d == S_DONE);
    sr_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      result_q <= '0;
      rv_q     <= 1'b0;
      sv_q     <= 1'b0;
      sr_q     <= 1'b1;
      a_n_q    <= 3'd1;
      w_n_q    <= 3'd1;
      ch_n_q   <= CHUNK_W'(1);
`ifdef PE_ACC_SAT_EN
      sat_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      rv_q     <= rv_d;
      sv_q     <= sv_d;
      sr_q     <= sr_d;
      a_n_q    <= a_n_d;
      w_n_q    <= w_n_d;
      ch_n_q   <= ch_n_d;
`ifdef PE_ACC_SAT_EN
      sat_q    <= sat_d;
`endif
    end
  end

  assign start_ready  = sr_q;
  assign step_valid   = sv_q;
  assign result_valid = rv_q;
  assign result       = result_q;

  logic unused_ovf;
  assign unused_ovf = ovf;

endmodule

// File: tb/tb_pe_bitslice_acc_ctrl.sv
// Directed bench for pe_bitslice_acc_ctrl (default and 12-bit acc builds).
// Honours PE_ACC_SAT_EN for the saturation expectations.
module tb_pe_bitslice_acc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        start_ready;
  logic [2:0]  cfg_a, cfg_w;
  logic [7:0]  cfg_ch;
  logic [9:0]  pe_sum;
  logic [1:0]  sel_a, sel_w;
  logic [7:0]  chunk_idx;
  logic        step_valid;
  logic [23:0] result;
  logic        result_valid;
  logic        result_ready;

  logic        start12;
  logic        sr12;
  logic [1:0]  sa12, sw12;
  logic [7:0]  ci12;
  logic        sv12;
  logic [11:0] res12;
  logic        rv12;
`ifdef PE_ACC_SAT_EN
  logic        sat, sat12;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pe_bitslice_acc_ctrl u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .start_ready  (start_ready),
    .cfg_a_slices (cfg_a),
    .cfg_w_slices (cfg_w),
    .cfg_chunks   (cfg_ch),
    .pe_sum       (pe_sum),
    .sel_a_slice  (sel_a),
    .sel_w_slice  (sel_w),
    .chunk_idx    (chunk_idx),
    .step_valid   (step_valid),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready)
`ifdef PE_ACC_SAT_EN
    ,
    .acc_sat      (sat)
`endif
  );

  pe_bitslice_acc_ctrl #(.ACC_W(12)) u_dut12 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start12),
    .start_ready  (sr12),
    .cfg_a_slices (3'd1),
    .cfg_w_slices (3'd1),
    .cfg_chunks   (8'd5),
    .pe_sum       (10'd511),
    .sel_a_slice  (sa12),
    .sel_w_slice  (sw12),
    .chunk_idx    (ci12),
    .step_valid   (sv12),
    .result       (res12),
    .result_valid (rv12),
    .result_ready (1'b1)
`ifdef PE_ACC_SAT_EN
    ,
    .acc_sat      (sat12)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start12 = 1'b0;
    cfg_a = 3'd1; cfg_w = 3'd1; cfg_ch = 8'd1;
    pe_sum = '0; result_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_sr", 32'(start_ready), 32'd1);
    chk("rst_sv", 32'(step_valid), 32'd0);
    chk("rst_rv", 32'(result_valid), 32'd0);
    chk("rst_res", 32'(result), 32'd0);
    chk("rst_sel", {sel_a, sel_w, chunk_idx}, 32'd0);

    // 1: single step
    cfg_a = 3'd1; cfg_w = 3'd1; cfg_ch = 8'd1; pe_sum = 10'd5;
    start = 1'b1;
    tick(); start = 1'b0;
    chk("t1_sv", 32'(step_valid), 32'd1);
    chk("t1_sr", 32'(start_ready), 32'd0);
    tick();
    chk("t1_sv_off", 32'(step_valid), 32'd0);
    chk("t1_rv", 32'(result_valid), 32'd1);
    chk("t1_res", 32'(result), 32'd5);
    result_ready = 1'b1;
    tick();
    chk("t1_idle", {30'd0, start_ready, result_valid}, 32'd2);

    // 2: 2x2 slices, pe_sum=1 -> 1+4+4+16
    cfg_a = 3'd2; cfg_w = 3'd2; cfg_ch = 8'd1; pe_sum = 10'd1;
    start = 1'b1;
    tick(); start = 1'b0;
    chk("t2_s0", {step_valid, sel_a, sel_w}, {27'd0, 5'b1_00_00});
    tick();
    chk("t2_s1", {step_valid, sel_a, sel_w}, {27'd0, 5'b1_01_00});
    tick();
    chk("t2_s2", {step_valid, sel_a, sel_w}, {27'd0, 5'b1_00_01});
    tick();
    chk("t2_s3", {step_valid, sel_a, sel_w}, {27'd0, 5'b1_01_01});
    tick();
    chk("t2_rv", 32'(result_valid), 32'd1);
    chk("t2_res", 32'(result), 32'd25);
    chk("t2_sel0", {sel_a, sel_w, chunk_idx}, 32'd0);
    tick();

    // 3 + 4: negative sum, then backpressure with start held
    cfg_a = 3'd1; cfg_w = 3'd2; pe_sum = 10'h3FD;
    result_ready = 1'b0;
    start = 1'b1;
    tick(); start = 1'b0;
    tick();
    chk("t3_sv", 32'(step_valid), 32'd1);
    tick();
    chk("t3_rv", 32'(result_valid), 32'd1);
    chk("t3_res", 32'(result), 32'h00FFFFF1);
    cfg_a = 3'd1; cfg_w = 3'd1; cfg_ch = 8'd1; pe_sum = 10'd5;
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold", {result_valid, start_ready, step_valid, result},
          {8'd0, 3'b100, 24'hFFFFF1});
    end
    result_ready = 1'b1;
    tick();
    chk("t4_hs", {29'd0, start_ready, step_valid, result_valid},
        32'b100);
    result_ready = 1'b0;
    tick(); start = 1'b0;
    chk("t4_acc", 32'(step_valid), 32'd1);
    tick();
    chk("t4_res", {result_valid, result}, {7'd0, 1'b1, 24'd5});
    result_ready = 1'b1;
    tick();

    // clamp: a=0->1, w=7->4, chunks=0->1 -> 1+4+16+64
    cfg_a = 3'd0; cfg_w = 3'd7; cfg_ch = 8'd0; pe_sum = 10'd1;
    start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("cl_s3", {step_valid, sel_a, sel_w, chunk_idx},
        {19'd0, 1'b1, 2'd0, 2'd3, 8'd0});
    tick();
    chk("cl_res", {result_valid, result}, {7'd0, 1'b1, 24'd85});
    tick();

    // chunk index walk
    cfg_a = 3'd1; cfg_w = 3'd1; cfg_ch = 8'd3; pe_sum = 10'd2;
    start = 1'b1;
    tick(); start = 1'b0;
    chk("ch_0", 32'(chunk_idx), 32'd0);
    tick();
    chk("ch_1", 32'(chunk_idx), 32'd1);
    tick();
    chk("ch_2", 32'(chunk_idx), 32'd2);
    tick();
    chk("ch_res", {result_valid, result, chunk_idx}, {1'b1, 24'd6, 8'd0});
    tick();

    // 5: reset mid job
    cfg_a = 3'd4; cfg_w = 3'd4; cfg_ch = 8'd3; pe_sum = 10'd1;
    start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("t5_s6", {step_valid, sel_a, sel_w}, {27'd0, 5'b1_10_01});
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5_rst", {start_ready, step_valid, result_valid, sel_a, sel_w,
                   chunk_idx}, {17'd0, 3'b100, 12'd0});
    chk("t5_res", 32'(result), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    chk("t5_norv", {30'd0, result_valid, start_ready}, 32'd1);

    // 6: 12-bit accumulator, 5 x 511
    start12 = 1'b1;
    tick(); start12 = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("t6_rv", 32'(rv12), 32'd1);
`ifdef PE_ACC_SAT_EN
    chk("t6_res", 32'(res12), 32'h7FF);
    chk("t6_sat", 32'(sat12), 32'd1);
    chk("sat_main", 32'(sat), 32'd0);
`else
    chk("t6_res", 32'(res12), 32'h9FB);
`endif
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
